// File: rtl/reg_file_rename.sv
// reg_file_rename: architectural register file (x0..x31) with a per-register
// rename table. The dispatcher queries source operands and renames
// destinations, and the reorder buffer writes back committed results.
// Optional build macro: REGFILE_COMMIT_BYPASS_EN forwards the current cycle's
// commit onto the query outputs. Without it, a commit becomes visible one
// cycle later.
module reg_file_rename #(
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 4,
    parameter int NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback_signal,
    input  logic                commit_en,
    input  logic [4:0]          commit_rd,
    input  logic [DATA_W-1:0]   commit_val,
    input  logic [ROB_ID_W-1:0] commit_alias,
    input  logic                rename_en,
    input  logic [4:0]          rename_rd,
    input  logic [ROB_ID_W-1:0] rename_alias,
    input  logic [4:0]          rs1_idx,
    input  logic [4:0]          rs2_idx,
    output logic                rs1_busy,
    output logic [ROB_ID_W-1:0] rs1_alias,
    output logic [DATA_W-1:0]   rs1_val,
    output logic                rs2_busy,
    output logic [ROB_ID_W-1:0] rs2_alias,
    output logic [DATA_W-1:0]   rs2_val
);

    typedef struct packed {
        logic                busy;
        logic [ROB_ID_W-1:0] rob_id;
        logic [DATA_W-1:0]   val;
    } query_t;

    logic [DATA_W-1:0]   val_q   [NUM_REGS];
    logic [ROB_ID_W-1:0] alias_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;

    // Entry 0 is never written, so x0 stays at its reset value of zero.
    logic commit_wr;
    logic rename_wr;
    logic commit_clears;

    assign commit_wr     = commit_en && (commit_rd != 5'd0);
    assign rename_wr     = rename_en && (rename_rd != 5'd0);
    assign commit_clears = commit_wr && busy_q[commit_rd] &&
                           (alias_q[commit_rd] == commit_alias);

    // Register state update. Priority: reset, then stall, then rollback, then normal.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the value array is cleared on reset because x0..x31 must read
            // zero after reset. This is a real reset of the memory, not only of
            // the control bits.
            for (int i = 0; i < NUM_REGS; i++) begin
                val_q[i]   <= '0;
                alias_q[i] <= '0;
            end
            busy_q <= '0;
        end else if (rdy) begin
            // The ROB may commit the mispredicted branch's own result while it
            // raises rollback, so the value write is outside the rollback branch.
            if (commit_wr) begin
                val_q[commit_rd] <= commit_val;
            end
            if (rollback_signal) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    alias_q[i] <= '0;
                end
                busy_q <= '0;
            end else begin
                // NOTE: the rename assignment comes after the commit-clear on
                // purpose. With non-blocking assignments the last write to the
                // same element wins, so a same-cycle rename keeps ownership.
                if (commit_clears) begin
                    busy_q[commit_rd]  <= 1'b0;
                    alias_q[commit_rd] <= '0;
                end
                if (rename_wr) begin
                    busy_q[rename_rd]  <= 1'b1;
                    alias_q[rename_rd] <= rename_alias;
                end
            end
        end
    end

    // One source-operand lookup. The result reflects state before this
    // cycle's rename, optionally with the current commit forwarded.
    function automatic query_t read_port(input logic [4:0] idx);
        query_t q;
        q.busy = busy_q[idx];
        q.val  = val_q[idx];
`ifdef REGFILE_COMMIT_BYPASS_EN
        if (rdy && !rollback_signal && commit_wr && (commit_rd == idx)) begin
            q.val = commit_val;
            if (q.busy && (alias_q[idx] == commit_alias)) begin
                q.busy = 1'b0;
            end
        end
`endif
        q.rob_id = q.busy ? alias_q[idx] : '0;
        return q;
    endfunction

    query_t rs1_q;
    query_t rs2_q;

    // Combinational source queries for both dispatcher read ports.
    always_comb begin
        // NOTE: every output of this block is assigned unconditionally, so no
        // latch can be inferred.
        rs1_q = read_port(rs1_idx);
        rs2_q = read_port(rs2_idx);
    end

    assign rs1_busy  = rs1_q.busy;
    assign rs1_alias = rs1_q.rob_id;
    assign rs1_val   = rs1_q.val;
    assign rs2_busy  = rs2_q.busy;
    assign rs2_alias = rs2_q.rob_id;
    assign rs2_val   = rs2_q.val;

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed-vector bench for reg_file_rename. Expected values are worked out by
// hand from the intended behaviour. Build with or without
// REGFILE_COMMIT_BYPASS_EN; the same-cycle commit checks adapt to the build.
module tb_reg_file_rename;

    localparam int DATA_W   = 32;
    localparam int ROB_ID_W = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                rdy;
    logic                rollback_signal;
    logic                commit_en;
    logic [4:0]          commit_rd;
    logic [DATA_W-1:0]   commit_val;
    logic [ROB_ID_W-1:0] commit_alias;
    logic                rename_en;
    logic [4:0]          rename_rd;
    logic [ROB_ID_W-1:0] rename_alias;
    logic [4:0]          rs1_idx;
    logic [4:0]          rs2_idx;
    logic                rs1_busy;
    logic [ROB_ID_W-1:0] rs1_alias;
    logic [DATA_W-1:0]   rs1_val;
    logic                rs2_busy;
    logic [ROB_ID_W-1:0] rs2_alias;
    logic [DATA_W-1:0]   rs2_val;

    int vectors     = 0;
    int miscompares = 0;

    // Expected architectural values, updated by hand alongside the stimulus.
    logic [DATA_W-1:0] exp_val [32];

    reg_file_rename #(.DATA_W(DATA_W), .ROB_ID_W(ROB_ID_W), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback_signal(rollback_signal),
        .commit_en(commit_en), .commit_rd(commit_rd), .commit_val(commit_val),
        .commit_alias(commit_alias), .rename_en(rename_en), .rename_rd(rename_rd),
        .rename_alias(rename_alias), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rs1_busy(rs1_busy), .rs1_alias(rs1_alias), .rs1_val(rs1_val),
        .rs2_busy(rs2_busy), .rs2_alias(rs2_alias), .rs2_val(rs2_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rollback_signal = 1'b0;
        commit_en       = 1'b0;
        commit_rd       = '0;
        commit_val      = '0;
        commit_alias    = '0;
        rename_en       = 1'b0;
        rename_rd       = '0;
        rename_alias    = '0;
    endtask

    task automatic do_rename(input logic [4:0] rd, input logic [ROB_ID_W-1:0] a);
        rename_en    = 1'b1;
        rename_rd    = rd;
        rename_alias = a;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [DATA_W-1:0] v,
                             input logic [ROB_ID_W-1:0] a);
        commit_en    = 1'b1;
        commit_rd    = rd;
        commit_val   = v;
        commit_alias = a;
    endtask

    // Query one register on both ports and compare both against the same expectation.
    task automatic expect_reg(input string tag, input logic [4:0] idx, input logic b,
                              input logic [ROB_ID_W-1:0] a, input logic [DATA_W-1:0] v);
        rs1_idx = idx;
        rs2_idx = idx;
        #1;
        check({tag, " rs1_busy"},  64'(rs1_busy),  64'(b));
        check({tag, " rs1_alias"}, 64'(rs1_alias), 64'(a));
        check({tag, " rs1_val"},   64'(rs1_val),   64'(v));
        check({tag, " rs2_busy"},  64'(rs2_busy),  64'(b));
        check({tag, " rs2_alias"}, 64'(rs2_alias), 64'(a));
        check({tag, " rs2_val"},   64'(rs2_val),   64'(v));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) exp_val[i] = '0;
        rst = 1'b1;
        rdy = 1'b1;
        rs1_idx = '0;
        rs2_idx = '0;
        idle();
        step();
        step();
        rst = 1'b0;

        // Reset state.
        expect_reg("reset x5", 5'd5, 1'b0, 4'd0, 32'h0);

        // Rename x3, then a matching commit releases it.
        do_rename(5'd3, 4'd2);
        step(); idle();
        expect_reg("renamed x3", 5'd3, 1'b1, 4'd2, 32'h0);
        do_commit(5'd3, 32'hDEADBEEF, 4'd2);
        step(); idle();
        exp_val[3] = 32'hDEADBEEF;
        expect_reg("committed x3", 5'd3, 1'b0, 4'd0, 32'hDEADBEEF);

        // A stale commit writes the value, but the younger producer keeps ownership.
        do_rename(5'd4, 4'd3);
        step(); idle();
        do_rename(5'd4, 4'd7);
        step(); idle();
        do_commit(5'd4, 32'h11, 4'd3);
        step(); idle();
        exp_val[4] = 32'h11;
        expect_reg("stale commit x4", 5'd4, 1'b1, 4'd7, 32'h11);

        // Same-cycle commit and rename on x6: the rename wins for busy and alias.
        do_rename(5'd6, 4'd1);
        step(); idle();
        do_commit(5'd6, 32'h22, 4'd1);
        do_rename(5'd6, 4'd5);
        step(); idle();
        exp_val[6] = 32'h22;
        expect_reg("commit+rename x6", 5'd6, 1'b1, 4'd5, 32'h22);

        // Rename x1..x8, then roll back with a commit to x9 and an ignored rename of x10.
        for (int i = 1; i <= 8; i++) begin
            do_rename(5'(i), 4'(i));
            step(); idle();
        end
        expect_reg("pre-rollback x8", 5'd8, 1'b1, 4'd8, 32'h0);
        rollback_signal = 1'b1;
        do_commit(5'd9, 32'h33, 4'd9);
        do_rename(5'd10, 4'd6);
        step(); idle();
        exp_val[9] = 32'h33;
        for (int i = 1; i <= 10; i++) begin
            expect_reg($sformatf("rollback x%0d", i), 5'(i), 1'b0, 4'd0, exp_val[i]);
        end

        // Writes and renames to x0 are dropped.
        do_commit(5'd0, 32'h55, 4'd3);
        do_rename(5'd0, 4'd3);
        step(); idle();
        expect_reg("x0 write", 5'd0, 1'b0, 4'd0, 32'h0);

        // With rdy low, renames, commits and rollback are all ignored.
        do_rename(5'd7, 4'd9);
        step(); idle();
        rdy = 1'b0;
        do_rename(5'd2, 4'd4);
        do_commit(5'd5, 32'h66, 4'd1);
        step(); idle();
        rollback_signal = 1'b1;
        step(); idle();
        rdy = 1'b1;
        expect_reg("hold x2", 5'd2, 1'b0, 4'd0, 32'h0);
        expect_reg("hold x5", 5'd5, 1'b0, 4'd0, 32'h0);
        expect_reg("hold x7", 5'd7, 1'b1, 4'd9, 32'h0);

        // Same-cycle visibility of a matching commit.
        do_rename(5'd3, 4'd2);
        step(); idle();
        do_commit(5'd3, 32'h44, 4'd2);
`ifdef REGFILE_COMMIT_BYPASS_EN
        expect_reg("bypass x3 same cycle", 5'd3, 1'b0, 4'd0, 32'h44);
`else
        expect_reg("no-bypass x3 same cycle", 5'd3, 1'b1, 4'd2, 32'hDEADBEEF);
`endif
        step(); idle();
        expect_reg("x3 after commit", 5'd3, 1'b0, 4'd0, 32'h44);

        // Same-cycle commit whose alias does not match: only the value may forward.
        do_rename(5'd5, 4'd6);
        step(); idle();
        do_commit(5'd5, 32'h77, 4'd1);
`ifdef REGFILE_COMMIT_BYPASS_EN
        expect_reg("bypass x5 alias miss", 5'd5, 1'b1, 4'd6, 32'h77);
`else
        expect_reg("no-bypass x5 alias miss", 5'd5, 1'b1, 4'd6, 32'h0);
`endif
        step(); idle();
        expect_reg("x5 after stale commit", 5'd5, 1'b1, 4'd6, 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
